regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 31 +++
 rtl/regfile_wb_arbiter_wb_slot.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, source encodings, slot payload and arbitration state for the
// register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned STALL_W  = 8;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ONE      = 2'd1,
    ARB_CONFLICT = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_payload_t;

  // Saturating increment for the conflict counter.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One write-back holding slot: full flag plus registered dest/data payload.
// Load and clear are never asserted together by the arbiter (load needs empty,
// clear needs full); clear is applied first so a stray overlap would reload.
module wb_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  wb_payload_t payload_i,
  output logic        full_o,
  output wb_payload_t payload_o
);

  logic        full_q, full_d;
  wb_payload_t payload_q, payload_d;

  // Next-state for the full flag and payload.
  always_comb begin
    full_d    = full_q;
    payload_d = payload_q;
    if (clear_i) full_d = 1'b0;
    if (load_i) begin
      full_d    = 1'b1;
      payload_d = payload_i;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      full_q    <= full_d;
      payload_q <= payload_d;
    end
  end

  assign full_o    = full_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: one holding slot each for ALU results and
// memory loads, one register-file write per cycle, pending-write scoreboard and
// a saturating count of conflict cycles.
// Optional feature macro WB_ROUND_ROBIN_EN: conflicts alternate between the two
// sources; when undefined MEM always beats ALU and no pointer is built.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                rf_w_en,
  output logic [ADDR_W-1:0]   rf_dest,
  output logic [DATA_W-1:0]   rf_w_in,
  output logic [NUM_REGS-1:0] busy,
  output logic [STALL_W-1:0]  stall_cnt
);

  logic        alu_full, mem_full;
  wb_payload_t alu_pl, mem_pl, alu_in, mem_in;
  logic        alu_load_c, mem_load_c;
  logic        grant_alu_c, grant_mem_c;
  arb_state_e  arb_state_c;

  logic                rf_w_en_q, rf_w_en_d;
  logic [ADDR_W-1:0]   rf_dest_q, rf_dest_d;
  logic [DATA_W-1:0]   rf_w_in_q, rf_w_in_d;
  logic [NUM_REGS-1:0] busy_q, busy_d, busy_set_c, busy_clr_c;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

`ifdef WB_ROUND_ROBIN_EN
  src_e last_q, last_d;
`endif

  assign alu_in     = '{dest: alu_dest, data: alu_data};
  assign mem_in     = '{dest: mem_dest, data: mem_data};
  // Ready comes straight from the full flops, so valid never loops into ready.
  assign alu_load_c = alu_valid & ~alu_full;
  assign mem_load_c = mem_valid & ~mem_full;

  wb_slot u_alu_slot (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (alu_load_c),
    .clear_i   (grant_alu_c),
    .payload_i (alu_in),
    .full_o    (alu_full),
    .payload_o (alu_pl)
  );

  wb_slot u_mem_slot (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (mem_load_c),
    .clear_i   (grant_mem_c),
    .payload_i (mem_in),
    .full_o    (mem_full),
    .payload_o (mem_pl)
  );

  // Classify slot occupancy and pick exactly one winner when any slot is full.
  always_comb begin
    arb_state_c = ARB_IDLE;
    grant_alu_c = 1'b0;
    grant_mem_c = 1'b0;
    case ({mem_full, alu_full})
      2'b01: begin
        arb_state_c = ARB_ONE;
        grant_alu_c = 1'b1;
      end
      2'b10: begin
        arb_state_c = ARB_ONE;
        grant_mem_c = 1'b1;
      end
      2'b11: begin
        arb_state_c = ARB_CONFLICT;
`ifdef WB_ROUND_ROBIN_EN
        if (last_q == SRC_MEM) grant_alu_c = 1'b1;
        else                   grant_mem_c = 1'b1;
`else
        grant_mem_c = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Next-state for the write port, scoreboard and conflict counter.
  always_comb begin
    rf_w_en_d   = grant_alu_c | grant_mem_c;
    rf_dest_d   = rf_dest_q;
    rf_w_in_d   = rf_w_in_q;
    stall_cnt_d = stall_cnt_q;
    busy_set_c  = '0;
    busy_clr_c  = '0;
`ifdef WB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    if (grant_mem_c) begin
      rf_dest_d = mem_pl.dest;
      rf_w_in_d = mem_pl.data;
`ifdef WB_ROUND_ROBIN_EN
      last_d    = SRC_MEM;
`endif
    end else if (grant_alu_c) begin
      rf_dest_d = alu_pl.dest;
      rf_w_in_d = alu_pl.data;
`ifdef WB_ROUND_ROBIN_EN
      last_d    = SRC_ALU;
`endif
    end
    if (arb_state_c == ARB_CONFLICT) stall_cnt_d = sat_inc(stall_cnt_q);
    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    if (rf_w_en_q) busy_clr_c = NUM_REGS'(1) << rf_dest_q;
    if (issue_en)  busy_set_c = NUM_REGS'(1) << issue_dest;
    busy_d = (busy_q & ~busy_clr_c) | busy_set_c;
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_w_en_q   <= 1'b0;
      rf_dest_q   <= '0;
      rf_w_in_q   <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      rf_w_en_q   <= rf_w_en_d;
      rf_dest_q   <= rf_dest_d;
      rf_w_in_q   <= rf_w_in_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  // Last-granted source; reset as if ALU had just been served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= SRC_ALU;
    else        last_q <= last_d;
  end
`endif

  assign alu_ready = ~alu_full;
  assign mem_ready = ~mem_full;
  assign rf_w_en   = rf_w_en_q;
  assign rf_dest   = rf_dest_q;
  assign rf_w_in   = rf_w_in_q;
  assign busy      = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a cycle-level reference model of the write-back
// rules, compared on every falling edge, plus directed literal expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_en;
  logic        alu_ready, mem_ready;
  logic [2:0]  alu_dest, mem_dest, issue_dest;
  logic [15:0] alu_data, mem_data;
  logic        rf_w_en;
  logic [2:0]  rf_dest;
  logic [15:0] rf_w_in;
  logic [7:0]  busy;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_dest   (alu_dest),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dest   (mem_dest),
    .mem_data   (mem_data),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .rf_w_en    (rf_w_en),
    .rf_dest    (rf_dest),
    .rf_w_in    (rf_w_in),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = ALU source, 1 = MEM source.
  bit          m_full [2];
  int          m_dest [2];
  int          m_data [2];
  int          m_last;
  int          m_rf   [8];
  int          m_w;
  bit          old_full [2];
  bit          e_wen;
  int          e_dest, e_data, e_busy, e_stall;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_full[0] = 0; m_full[1] = 0;
      m_last = 0;
      e_wen = 0; e_dest = 0; e_data = 0; e_busy = 0; e_stall = 0;
    end else begin
      old_full[0] = m_full[0];
      old_full[1] = m_full[1];
      m_w = -1;
      if (old_full[0] && old_full[1]) begin
`ifdef WB_ROUND_ROBIN_EN
        m_w = (m_last == 0) ? 1 : 0;
`else
        m_w = 1;
`endif
        e_stall = (e_stall >= 255) ? 255 : e_stall + 1;
      end else if (old_full[1]) m_w = 1;
      else if (old_full[0]) m_w = 0;
      if (e_wen) e_busy = e_busy & ~(1 << e_dest);
      if (issue_en) e_busy = e_busy | (1 << int'(issue_dest));
      e_wen = (m_w >= 0);
      if (m_w >= 0) begin
        e_dest = m_dest[m_w];
        e_data = m_data[m_w];
        m_full[m_w] = 0;
        m_last = m_w;
        m_rf[e_dest] = e_data;
      end
      if (alu_valid && !old_full[0]) begin
        m_full[0] = 1; m_dest[0] = int'(alu_dest); m_data[0] = int'(alu_data);
      end
      if (mem_valid && !old_full[1]) begin
        m_full[1] = 1; m_dest[1] = int'(mem_dest); m_data[1] = int'(mem_data);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("alu_ready", 32'(alu_ready), 32'(!m_full[0]));
    check("mem_ready", 32'(mem_ready), 32'(!m_full[1]));
    check("rf_w_en",   32'(rf_w_en),   32'(e_wen));
    check("rf_dest",   32'(rf_dest),   32'(e_dest));
    check("rf_w_in",   32'(rf_w_in),   32'(e_data));
    check("busy",      32'(busy),      32'(e_busy));
    check("stall_cnt", 32'(stall_cnt), 32'(e_stall));
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; issue_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    reset = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    issue_en = 0; issue_dest = 0;
    repeat (3) @(negedge clk);
    check("rst_wen",   32'(rf_w_en), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    reset = 1;
    @(negedge clk);
    check("post_rst_alu_ready", 32'(alu_ready), 1);
    check("post_rst_mem_ready", 32'(mem_ready), 1);

    // ALU-only write: visible two edges after the drive.
    alu_valid = 1; alu_dest = 3; alu_data = 16'h1234;
    @(negedge clk); idle_inputs();
    check("alu_only_ready_low", 32'(alu_ready), 0);
    check("alu_only_wen_early", 32'(rf_w_en), 0);
    @(negedge clk);
    check("alu_only_wen",  32'(rf_w_en), 1);
    check("alu_only_dest", 32'(rf_dest), 3);
    check("alu_only_data", 32'(rf_w_in), 32'h1234);
    @(negedge clk);
    check("alu_only_single", 32'(rf_w_en), 0);
    check("alu_only_hold",   32'(rf_w_in), 32'h1234);

    // Conflict: MEM first, ALU next, one stall cycle.
    alu_valid = 1; alu_dest = 2; alu_data = 16'hAAAA;
    mem_valid = 1; mem_dest = 5; mem_data = 16'h5555;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    check("cfl_first_dest", 32'(rf_dest), 5);
    check("cfl_first_data", 32'(rf_w_in), 32'h5555);
    check("cfl_stall",      32'(stall_cnt), 1);
    @(negedge clk);
    check("cfl_second_wen",  32'(rf_w_en), 1);
    check("cfl_second_dest", 32'(rf_dest), 2);
    check("cfl_second_data", 32'(rf_w_in), 32'hAAAA);
    @(negedge clk);
    check("cfl_done", 32'(rf_w_en), 0);

    // Same destination: loser value lands last.
    alu_valid = 1; alu_dest = 4; alu_data = 16'h0001;
    mem_valid = 1; mem_dest = 4; mem_data = 16'h0002;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    check("same_first", 32'(rf_w_in), 32'h0002);
    @(negedge clk);
    check("same_second", 32'(rf_w_in), 32'h0001);
    check("same_stall",  32'(stall_cnt), 2);
    check("model_r4",    32'(m_rf[4]), 1);

    // Scoreboard set, clear, and set-wins-over-clear.
    issue_en = 1; issue_dest = 6;
    @(negedge clk); issue_en = 0;
    check("sb_set", 32'(busy), 32'h40);
    alu_valid = 1; alu_dest = 6; alu_data = 16'h0606;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    check("sb_write_pending", 32'(busy), 32'h40);
    @(negedge clk);
    check("sb_clear", 32'(busy), 0);
    issue_en = 1; issue_dest = 6;
    alu_valid = 1; alu_dest = 6; alu_data = 16'h0666;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    check("sb_w_en_r6", 32'(rf_w_en), 1);
    issue_en = 1; issue_dest = 6;
    @(negedge clk); issue_en = 0;
    check("sb_set_wins", 32'(busy), 32'h40);

    // Valid held while not ready is ignored; data changes every cycle.
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_dest = 3'(i); alu_data = 16'(16'h0100 + i);
      @(negedge clk);
    end
    idle_inputs();
    repeat (3) @(negedge clk);

    // Repeated conflicts until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      alu_valid = 1; alu_dest = 1; alu_data = 16'(i);
      mem_valid = 1; mem_dest = 7; mem_data = 16'(16'h8000 + i);
      @(negedge clk); idle_inputs();
      repeat (2) @(negedge clk);
    end
    check("sat_255", 32'(stall_cnt), 255);
    check("model_sat_255", 32'(e_stall), 255);
    alu_valid = 1; mem_valid = 1;
    @(negedge clk); idle_inputs();
    repeat (2) @(negedge clk);
    check("sat_hold", 32'(stall_cnt), 255);

    // Reset with both slots full: everything clears immediately, nothing drains.
    alu_valid = 1; alu_dest = 2; alu_data = 16'hBEEF;
    mem_valid = 1; mem_dest = 3; mem_data = 16'hCAFE;
    @(negedge clk); idle_inputs();
    #2 reset = 0;
    #1;
    check("mid_rst_wen",   32'(rf_w_en), 0);
    check("mid_rst_dest",  32'(rf_dest), 0);
    check("mid_rst_data",  32'(rf_w_in), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_stall", 32'(stall_cnt), 0);
    check("mid_rst_aready", 32'(alu_ready), 1);
    check("mid_rst_mready", 32'(mem_ready), 1);
    #1 reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_rst_no_write", 32'(rf_w_en), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
